// File: rtl/full_adder_pkg.sv
// Shared constants and helpers for the registered ripple-carry adder.
// Holds the legal operand-width range and its check function.
package full_adder_pkg;

    localparam int unsigned FA_MIN_WIDTH = 1;
    localparam int unsigned FA_MAX_WIDTH = 64;

    function automatic bit fa_width_ok(input int unsigned w);
        return (w >= FA_MIN_WIDTH) && (w <= FA_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Purely combinational 1-bit full-adder slice.
// Ports: a, b, carryIn -> sum, carryOut.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic carryIn,
    output logic sum,
    output logic carryOut
);

    logic p;

    // Propagate term is shared by the sum and the carry.
    assign p        = a ^ b;
    assign sum      = p ^ carryIn;
    assign carryOut = (a & b) | (carryIn & p);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {carryOut, sum} = a + b + carryIn, 1-cycle latency.
// Ports: clk, resetN (sync, active-low), inValid, a, b, carryIn -> sum, carryOut, outValid.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             inValid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             outValid
);

    if (!fa_width_ok(WIDTH)) begin : g_bad_width
        $error("full_adder: WIDTH must be in 1..64");
    end

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = carryIn;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        full_adder_bit u_bit (
            .a        (a[i]),
            .b        (b[i]),
            .carryIn  (c[i]),
            .sum      (s[i]),
            .carryOut (c[i+1])
        );
    end

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_out_d, carry_out_q;
    logic             out_valid_d, out_valid_q;

    // Result registers only load on a valid operand; otherwise they hold.
    always_comb begin
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        out_valid_d = inValid;
        if (inValid) begin
            sum_d       = s;
            carry_out_d = c[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum      = sum_q;
    assign carryOut = carry_out_q;
    assign outValid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=8.
// Vector tables plus scoreboard queues of expected results.
module tb_full_adder;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
        logic       v;
    } exp_t;

    typedef struct packed {
        logic a;
        logic b;
        logic ci;
        logic s;
        logic co;
    } vec1_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
    } vec8_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r1, v1, a1, b1, c1;
    logic       s1, co1, ov1;
    logic       r8, v8, c8;
    logic [7:0] a8, b8, s8;
    logic       co8, ov8;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk      (clk),
        .resetN   (r1),
        .inValid  (v1),
        .a        (a1),
        .b        (b1),
        .carryIn  (c1),
        .sum      (s1),
        .carryOut (co1),
        .outValid (ov1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .resetN   (r8),
        .inValid  (v8),
        .a        (a8),
        .b        (b8),
        .carryIn  (c8),
        .sum      (s8),
        .carryOut (co8),
        .outValid (ov8)
    );

    int   tests  = 0;
    int   failed = 0;
    exp_t q1[$];
    exp_t q8[$];

    // Bench model of the 8-bit result registers, used for hold checks.
    logic [7:0] m_s  = 8'h00;
    logic       m_co = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step1(input logic rst, input logic vld, input logic a,
                         input logic b, input logic ci, input logic es,
                         input logic eco, input logic ev, input string nm);
        exp_t e;
        r1 = rst; v1 = vld; a1 = a; b1 = b; c1 = ci;
        q1.push_back('{s: {7'b0, es}, co: eco, v: ev});
        @(posedge clk);
        #1;
        e = q1.pop_front();
        chk({nm, ".sum"}, {7'b0, s1}, e.s);
        chk({nm, ".co"},  {7'b0, co1}, {7'b0, e.co});
        chk({nm, ".vld"}, {7'b0, ov1}, {7'b0, e.v});
    endtask

    task automatic step8(input logic rst, input logic vld,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input string nm);
        exp_t       e;
        logic [8:0] full;
        r8 = rst; v8 = vld; a8 = a; b8 = b; c8 = ci;
        full = {1'b0, a} + {1'b0, b} + {8'b0, ci};
        if (!rst) begin
            m_s  = 8'h00;
            m_co = 1'b0;
        end else if (vld) begin
            m_s  = full[7:0];
            m_co = full[8];
        end
        q8.push_back('{s: m_s, co: m_co, v: rst & vld});
        @(posedge clk);
        #1;
        e = q8.pop_front();
        chk({nm, ".sum"}, s8, e.s);
        chk({nm, ".co"},  {7'b0, co8}, {7'b0, e.co});
        chk({nm, ".vld"}, {7'b0, ov8}, {7'b0, e.v});
    endtask

    vec1_t t1[8];
    vec8_t t8[3];

    initial begin
        t1[0] = '{a: 0, b: 0, ci: 0, s: 0, co: 0};
        t1[1] = '{a: 1, b: 0, ci: 0, s: 1, co: 0};
        t1[2] = '{a: 0, b: 1, ci: 0, s: 1, co: 0};
        t1[3] = '{a: 1, b: 1, ci: 0, s: 0, co: 1};
        t1[4] = '{a: 0, b: 0, ci: 1, s: 1, co: 0};
        t1[5] = '{a: 1, b: 0, ci: 1, s: 0, co: 1};
        t1[6] = '{a: 0, b: 1, ci: 1, s: 0, co: 1};
        t1[7] = '{a: 1, b: 1, ci: 1, s: 1, co: 1};
        t8[0] = '{a: 8'hFF, b: 8'h01, ci: 0, s: 8'h00, co: 1};
        t8[1] = '{a: 8'h7F, b: 8'h80, ci: 1, s: 8'h00, co: 1};
        t8[2] = '{a: 8'h12, b: 8'h34, ci: 0, s: 8'h46, co: 0};

        r1 = 0; v1 = 0; a1 = 0; b1 = 0; c1 = 0;
        r8 = 0; v8 = 0; a8 = 0; b8 = 0; c8 = 0;
        @(posedge clk);
        #1;
        step1(0, 1, 1, 1, 1, 0, 0, 0, "rst1_a");
        step1(0, 1, 1, 1, 1, 0, 0, 0, "rst1_b");
        step1(1, 1, 1, 1, 1, 1, 1, 1, "rst1_rel");
        step8(0, 1, 8'hFF, 8'hFF, 1, "rst8");

        for (int i = 0; i < 8; i++)
            step1(1, 1, t1[i].a, t1[i].b, t1[i].ci,
                  t1[i].s, t1[i].co, 1, $sformatf("w1_vec%0d", i));

        for (int i = 0; i < 3; i++) begin
            step8(1, 1, t8[i].a, t8[i].b, t8[i].ci, $sformatf("w8_vec%0d", i));
            chk($sformatf("w8_tab%0d.sum", i), s8, t8[i].s);
            chk($sformatf("w8_tab%0d.co", i), {7'b0, co8}, {7'b0, t8[i].co});
        end

        step8(1, 1, 8'hFF, 8'hFF, 1, "ones");
        chk("ones_tab.sum", s8, 8'hFF);
        step8(1, 1, 8'h00, 8'h00, 0, "zeros");
        chk("zeros_tab.sum", s8, 8'h00);

        step8(1, 1, 8'h0A, 8'h05, 0, "hold_ld");
        chk("hold_ld_tab.sum", s8, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            step8(1, 0, 8'(i * 37 + 1), 8'(i * 91 + 3), i[0],
                  $sformatf("hold%0d", i));
            chk($sformatf("hold%0d_tab.sum", i), s8, 8'h0F);
        end

        for (int i = 0; i < 256; i++)
            step8(1, 1, 8'($urandom_range(255)), 8'($urandom_range(255)),
                  1'($urandom_range(1)), "b2b");

        for (int i = 0; i < 20; i++)
            step8(i != 10, 1, 8'($urandom_range(255)),
                  8'($urandom_range(255)), 1'($urandom_range(1)),
                  (i == 10) ? "mid_rst" : "stream");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
